// File: rtl/fxp_pkg.sv
// Fixed-point format constants and helpers shared by the dense MAC layer.
// Covers the element format, activation encodings and accumulator sizing.
package fxp_pkg;

  localparam int BITSIZE_DEF = 16;
  localparam int FRAC_DEF    = 10;

  localparam int ACT_NONE = 0;
  localparam int ACT_RELU = 1;

  typedef enum logic {
    IDLE,
    ACC
  } layer_state_t;

  function automatic int acc_width(input int bits, input int n);
    return bits + $clog2(n) + 1;
  endfunction

  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(BITSIZE_DEF);
  localparam longint SAT_MIN_DEF = sat_min(BITSIZE_DEF);

endpackage

// File: rtl/dense_mac_lane.sv
// One output channel: multiply, shift by FRAC, accumulate.
// acc_nx exposes the running sum so the final term lands in y directly.
module dense_mac_lane
  import fxp_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int AW      = acc_width(BITSIZE_DEF, 10)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [BITSIZE-1:0] bias,
  input  logic [BITSIZE-1:0] xj,
  input  logic [BITSIZE-1:0] wji,
  output logic [AW-1:0]     acc_nx
);

  logic signed [2*BITSIZE-1:0] prod_full;
  logic signed [2*BITSIZE-1:0] prod_sh;
  logic signed [AW-1:0]        prod_a;
  logic signed [AW-1:0]        bias_a;
  logic signed [AW-1:0]        acc;
  logic signed [AW-1:0]        sum;

  assign prod_full = signed'(xj) * signed'(wji);
  // Arithmetic shift floors toward minus infinity.
  assign prod_sh   = prod_full >>> FRAC;
  assign prod_a    = AW'(prod_sh);
  assign bias_a    = AW'(signed'(bias));
  assign sum       = acc + prod_a;
  assign acc_nx    = sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= bias_a;
    end else if (step) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/dense_mac_layer.sv
// Dense layer: N_OUT parallel MAC lanes stepped over N_IN inputs.
// Result goes through optional ReLU and saturation into a held y register.
module dense_mac_layer
  import fxp_pkg::*;
#(
  parameter int BITSIZE     = BITSIZE_DEF,
  parameter int FRAC        = FRAC_DEF,
  parameter int N_IN        = 10,
  parameter int N_OUT       = 6,
  parameter int ACT         = ACT_NONE,
  parameter int REVERSE_OUT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITSIZE*N_IN-1:0]    x,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]   b,
  output logic                       busy,
  output logic                       done,
  output logic [BITSIZE*N_OUT-1:0]   y
);

  localparam int AW = acc_width(BITSIZE, N_IN);
  localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [AW-1:0] HI = AW'(sat_max(BITSIZE));
  localparam logic signed [AW-1:0] LO = AW'(sat_min(BITSIZE));

  layer_state_t state, state_nx;
  logic [JW-1:0] j, j_nx;
  logic load, step, last;
  logic [BITSIZE-1:0] xj;

  assign last = (j == JW'(N_IN - 1));
  assign xj   = x[BITSIZE*j +: BITSIZE];

  always_comb begin
    state_nx = state;
    j_nx     = j;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          j_nx     = '0;
          state_nx = ACC;
        end
      end
      ACC: begin
        step = 1'b1;
        j_nx = j + 1'b1;
        if (last) begin
          j_nx     = '0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      j     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      j     <= j_nx;
      busy  <= (state_nx == ACC);
      done  <= step && last;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    localparam int S = (REVERSE_OUT != 0) ? (N_OUT - 1 - i) : i;

    logic [AW-1:0]        acc_nx;
    logic signed [AW-1:0] fin;
    logic signed [AW-1:0] rel;
    logic [BITSIZE-1:0]   sat;
    logic [BITSIZE-1:0]   y_r;
    logic [BITSIZE-1:0]   wji;

    assign wji = w[BITSIZE*N_OUT*j + BITSIZE*i +: BITSIZE];

    dense_mac_lane #(
      .BITSIZE(BITSIZE),
      .FRAC   (FRAC),
      .AW     (AW)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (step),
      .bias  (b[BITSIZE*i +: BITSIZE]),
      .xj    (xj),
      .wji   (wji),
      .acc_nx(acc_nx)
    );

    assign fin = signed'(acc_nx);

    always_comb begin
      rel = fin;
      if (ACT == ACT_RELU && fin < 0) begin
        rel = '0;
      end
    end

    always_comb begin
      sat = rel[BITSIZE-1:0];
      if (rel > HI) begin
        sat = HI[BITSIZE-1:0];
      end else if (rel < LO) begin
        sat = LO[BITSIZE-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        y_r <= '0;
      end else if (step && last) begin
        y_r <= sat;
      end
    end

    assign y[BITSIZE*S +: BITSIZE] = y_r;
  end

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed bench for dense_mac_layer: plain, ReLU and reversed-order builds.
// All three instances share stimulus; each check targets the relevant one.
module tb_dense_mac_layer;

  localparam int BS = 16;
  localparam int NI = 10;
  localparam int NO = 6;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [BS*NI-1:0]    x;
  logic [BS*NO*NI-1:0] w;
  logic [BS*NO-1:0]    b;

  logic busy0, done0, busy1, done1, busy2, done2;
  logic [BS*NO-1:0] y0, y1, y2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dense_mac_layer #(.ACT(0), .REVERSE_OUT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
    .busy(busy0), .done(done0), .y(y0)
  );

  dense_mac_layer #(.ACT(1), .REVERSE_OUT(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
    .busy(busy1), .done(done1), .y(y1)
  );

  dense_mac_layer #(.ACT(0), .REVERSE_OUT(1)) dut2 (
    .clk(clk), .reset(reset), .start(start), .x(x), .w(w), .b(b),
    .busy(busy2), .done(done2), .y(y2)
  );

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] xv, input logic [15:0] wv,
                         input logic [15:0] bv);
    for (int jj = 0; jj < NI; jj++) begin
      x[BS*jj +: BS] = xv;
      for (int ii = 0; ii < NO; ii++) w[BS*NO*jj + BS*ii +: BS] = wv;
    end
    for (int ii = 0; ii < NO; ii++) b[BS*ii +: BS] = bv;
  endtask

  // Pulse start, count busy cycles, stop at the done cycle (negedge).
  task automatic run(output int bcnt, output bit seen);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done0) begin
        seen = 1'b1;
        break;
      end
      if (busy0) bcnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;
    bit sn;
    int nd;
    int last_t;
    int gap_bad;
    logic [BS*NO-1:0] ev;

    reset = 1'b1;
    start = 1'b0;
    set_all(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", 96'(busy0), 96'd0);
    chk("rst_done", 96'(done0), 96'd0);
    chk("rst_y", 96'(y0), 96'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic: 1.0 * 0.5 summed ten times = 5.0
    set_all(16'h0400, 16'h0200, 16'h0000);
    run(bc, sn);
    chk("basic_done_seen", 96'(sn), 96'd1);
    chk("basic_busy_cycles", 96'(bc), 96'd10);
    chk("basic_busy_in_done", 96'(busy0), 96'd0);
    chk("basic_y", 96'(y0), {6{16'h1400}});
    @(negedge clk);
    chk("basic_done_one_cycle", 96'(done0), 96'd0);
    chk("basic_y_held", 96'(y0), {6{16'h1400}});

    // Positive saturation: 7*7*10 = 490
    set_all(16'h1C00, 16'h1C00, 16'h0000);
    run(bc, sn);
    chk("satp_seen", 96'(sn), 96'd1);
    chk("satp_y", 96'(y0), {6{16'h7FFF}});
    @(negedge clk);

    // Negative saturation
    set_all(16'h1C00, 16'hE400, 16'h0000);
    run(bc, sn);
    chk("satn_y", 96'(y0), {6{16'h8000}});
    chk("satn_relu_y", 96'(y1), 96'd0);
    @(negedge clk);

    // Floor rounding: (1 * -1) >>> 10 = -1 per term, ten terms = -10
    set_all(16'h0001, 16'hFFFF, 16'h0000);
    run(bc, sn);
    chk("floor_y", 96'(y0), {6{16'hFFF6}});
    @(negedge clk);

    // Activation: bias -1.0 with zero inputs
    set_all(16'h0000, 16'h0200, 16'hFC00);
    run(bc, sn);
    chk("act_none_y", 96'(y0), {6{16'hFC00}});
    chk("act_relu_y", 96'(y1), 96'd0);
    @(negedge clk);

    // Ordering: b[i] = i, reversed build puts channel 5 in slot 0
    set_all(16'h0000, 16'h0000, 16'h0000);
    for (int ii = 0; ii < NO; ii++) b[BS*ii +: BS] = 16'(ii * 16'h0400);
    run(bc, sn);
    chk("ord_rev_slot0", 96'(y2[0 +: BS]), 96'h1400);
    chk("ord_rev_slot5", 96'(y2[BS*5 +: BS]), 96'h0000);
    chk("ord_fwd_slot0", 96'(y0[0 +: BS]), 96'h0000);
    chk("ord_fwd_slot5", 96'(y0[BS*5 +: BS]), 96'h1400);
    @(negedge clk);

    // Start held high: start in the done cycle restarts, period N_IN+1
    set_all(16'h0400, 16'h0200, 16'h0000);
    start = 1'b1;
    nd = 0;
    last_t = -1;
    gap_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done0) begin
        if (last_t >= 0 && (c - last_t) != NI + 1) gap_bad++;
        last_t = c;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_done_count", 96'(nd), 96'd3);
    chk("held_gap_errors", 96'(gap_bad), 96'd0);
    chk("held_y", 96'(y0), {6{16'h1400}});
    for (int c = 0; c < 20 && (busy0 || done0); c++) @(negedge clk);
    chk("held_drained", 96'(busy0), 96'd0);

    // Start pulse mid-ACC must be ignored
    set_all(16'h0400, 16'h0100, 16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      if (done0) nd++;
      @(negedge clk);
    end
    chk("midstart_one_done", 96'(nd), 96'd1);
    chk("midstart_y", 96'(y0), {6{16'h0A00}});

    // Reset mid-run at j = 4
    set_all(16'h0400, 16'h0200, 16'h0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", 96'(busy0), 96'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 96'(busy0), 96'd0);
    chk("mid_rst_done", 96'(done0), 96'd0);
    chk("mid_rst_y", 96'(y0), 96'd0);
    reset = 1'b0;
    @(negedge clk);
    run(bc, sn);
    ev = {6{16'h1400}};
    chk("post_rst_seen", 96'(sn), 96'd1);
    chk("post_rst_busy", 96'(bc), 96'd10);
    chk("post_rst_y", 96'(y0), 96'(ev));
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
